// File: rtl/beamformer_sum_readout.sv
// Read-side sequencer for the beamformer summed-output RAM.
// Issues credit-limited reads, absorbs the RAM read latency through a tag
// pipeline and a small skid FIFO, and streams samples over ready/valid.
// Also tracks the peak |sample| and its index for each completed frame.

module beamformer_sum_readout_chk #(
  parameter int CW         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [CW-1:0] occ
);
  // A capture into a full FIFO would silently drop a returning sample.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ == CW'(FIFO_DEPTH))));
endmodule

module beamformer_sum_readout #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  output logic [ADDR_W-1:0] sumout_address,
  output logic              sumouten,
  input  logic [31:0]       output_value,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       peak_mag,
  output logic [ADDR_W-1:0] peak_idx
);
  localparam int LW = ADDR_W + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam logic [LW-1:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state_r;
  logic [LW-1:0]         len_r;
  logic [LW-1:0]         rd_cnt_r;
  logic [LW-1:0]         push_idx_r;
  logic [RD_LATENCY-1:0] tag_r;
  logic [CW-1:0]         inflight_r;
  logic [CW-1:0]         occ_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [31:0]           data_mem_r [FIFO_DEPTH];
  logic                  last_mem_r [FIFO_DEPTH];
  logic [31:0]           run_max_r;
  logic [ADDR_W-1:0]     run_idx_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  head_last_s;
  logic                  accept_s;
  logic                  credit_s;
  logic                  issue_last_s;
  logic                  push_last_s;
  logic [LW-1:0]         clamp_len_s;
  logic [31:0]           sample_abs_s;

  // Unsigned magnitude; the most negative value maps to 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    logic [31:0] r;
    if (x[31]) r = ~x + 32'd1;
    else       r = x;
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) r = {PW{1'b0}};
    else               r = p + PW'(1);
    return r;
  endfunction

  assign m_valid = (occ_r != {CW{1'b0}});
  assign m_data  = m_valid ? data_mem_r[rd_ptr_r] : 32'd0;
  assign m_last  = m_valid ? last_mem_r[rd_ptr_r] : 1'b0;

  // Handshake, credit and length decode for this cycle.
  always_comb begin
    push_s       = tag_r[RD_LATENCY-1];
    pop_s        = m_valid && m_ready;
    head_last_s  = last_mem_r[rd_ptr_r];
    sample_abs_s = abs32(output_value);
    accept_s     = start && (state_r == IDLE) && !done;
    issue_last_s = (rd_cnt_r == len_r - LW'(1));
    push_last_s  = (push_idx_r == len_r - LW'(1));
    // sumouten is registered, so the read being presented now already
    // counts against credit and a pop this cycle frees one slot early.
    credit_s = (occ_r + inflight_r + CW'(sumouten)) < (DEPTH_C + CW'(pop_s));
    if (frame_len > MAX_LEN) clamp_len_s = MAX_LEN;
    else                     clamp_len_s = frame_len;
  end

  // Frame sequencer: issues reads, waits for the last transfer, commits peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      len_r          <= {LW{1'b0}};
      rd_cnt_r       <= {LW{1'b0}};
      sumouten       <= 1'b0;
      sumout_address <= {ADDR_W{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
      peak_mag       <= 32'd0;
      peak_idx       <= {ADDR_W{1'b0}};
    end else begin
      done     <= 1'b0;
      sumouten <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (clamp_len_s == {LW{1'b0}}) begin
              done <= 1'b1;
            end else begin
              // First read goes out on the accepting edge.
              len_r          <= clamp_len_s;
              busy           <= 1'b1;
              sumouten       <= 1'b1;
              sumout_address <= {ADDR_W{1'b0}};
              rd_cnt_r       <= LW'(1);
              if (clamp_len_s == LW'(1)) state_r <= DRAIN;
              else                       state_r <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (credit_s) begin
            sumouten       <= 1'b1;
            sumout_address <= rd_cnt_r[ADDR_W-1:0];
            rd_cnt_r       <= rd_cnt_r + LW'(1);
            if (issue_last_s) state_r <= DRAIN;
          end
        end
        DRAIN: begin
          // The last-flagged entry is the only one left when it transfers.
          if (pop_s && head_last_s) begin
            state_r  <= FINISH;
            done     <= 1'b1;
            peak_mag <= run_max_r;
            peak_idx <= run_idx_r;
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Read-return tags, in-flight count and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r      <= {RD_LATENCY{1'b0}};
      inflight_r <= {CW{1'b0}};
      occ_r      <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      push_idx_r <= {LW{1'b0}};
    end else begin
      tag_r[0] <= sumouten;
      for (int i = 1; i < RD_LATENCY; i++) tag_r[i] <= tag_r[i-1];
      case ({sumouten, push_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (accept_s)    push_idx_r <= {LW{1'b0}};
      else if (push_s) push_idx_r <= push_idx_r + LW'(1);
    end
  end

  // FIFO storage: sample plus end-of-frame flag per entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= output_value;
      last_mem_r[wr_ptr_r] <= push_last_s;
    end
  end

  // Running peak; strict compare keeps the earliest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_r <= 32'd0;
      run_idx_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      run_max_r <= 32'd0;
      run_idx_r <= {ADDR_W{1'b0}};
    end else if (push_s && (sample_abs_s > run_max_r)) begin
      run_max_r <= sample_abs_s;
      run_idx_r <= push_idx_r[ADDR_W-1:0];
    end
  end

  beamformer_sum_readout_chk #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .occ  (occ_r)
  );

endmodule

// File: tb/tb_beamformer_sum_readout.sv
// Bench for beamformer_sum_readout: RAM model with two-cycle registered read,
// occupancy/credit model, and frame-level expectations from the RAM contents.

module tb_beamformer_sum_readout;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic              clk, rst, start, sumouten, m_valid, m_ready, m_last, busy, done;
  logic [ADDR_W:0]   frame_len;
  logic [ADDR_W-1:0] sumout_address, peak_idx;
  logic [31:0]       output_value, m_data, peak_mag;
  logic [31:0]       ram [1 << ADDR_W];
  logic [31:0]       ram_stage;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int occ_m = 0;
  bit h1, h2, mon_en, stall_pend, done_seen;
  logic [31:0] stall_d;
  logic stall_l;
  int done_cyc;
  logic [31:0] got_d[$];
  logic got_l[$];
  logic [ADDR_W-1:0] issued[$];

  beamformer_sum_readout #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .sumout_address(sumout_address), .sumouten(sumouten), .output_value(output_value),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .peak_mag(peak_mag), .peak_idx(peak_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output RAM: address sampled with rden, data out one clock later.
  always @(posedge clk) begin
    if (sumouten === 1'b1) ram_stage <= ram[sumout_address];
    output_value <= ram_stage;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the current cycle, advance one clock, update the occupancy model.
  task automatic tick();
    bit so, xf, rs;
    so = (sumouten === 1'b1);
    xf = (m_valid === 1'b1) && (m_ready === 1'b1);
    rs = (rst === 1'b1);
    if (mon_en) begin
      if (stall_pend) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(stall_d));
        check("stall_last", 64'(m_last), 64'(stall_l));
      end
      check("valid_vs_occupancy", 64'(m_valid), 64'(occ_m != 0));
      if (so) check("credit_limit", 64'((occ_m + int'(h1) + int'(h2)) < DEPTH), 64'd1);
    end
    if (so) issued.push_back(sumout_address);
    if (xf) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    stall_pend = mon_en && (m_valid === 1'b1) && (m_ready === 1'b0) && !rs;
    stall_d = m_data;
    stall_l = m_last;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      occ_m = 0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      occ_m = occ_m + int'(h2) - int'(xf);
      h2 = h1;
      h1 = so;
    end
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, "_sumouten"}, 64'(sumouten), 64'd0);
    check({pfx, "_addr"}, 64'(sumout_address), 64'd0);
    check({pfx, "_m_valid"}, 64'(m_valid), 64'd0);
    check({pfx, "_m_data"}, 64'(m_data), 64'd0);
    check({pfx, "_m_last"}, 64'(m_last), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_peak_mag"}, 64'(peak_mag), 64'd0);
    check({pfx, "_peak_idx"}, 64'(peak_idx), 64'd0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, other: random ready.
  task automatic run_frame(input logic [ADDR_W:0] len, input int mode, input bit chk_lat,
                           input bit mid_start);
    int eff, n, budget, bad, lbad, abad, busy_bad, start_cyc, bidx;
    longint mag, best;
    eff = (len > 11'd1024) ? 1024 : int'(len);
    got_d.delete(); got_l.delete(); issued.delete();
    done_seen = 1'b0;
    frame_len = len; m_ready = 1'b1; start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    n = 0; busy_bad = 0; budget = eff * 8 + 40;
    while (!done_seen && n < budget) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mid_start && n == 500) begin
        start = 1'b1; frame_len = 11'd5;
      end else begin
        start = 1'b0; frame_len = len;
      end
      if (busy !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    start = 1'b0; m_ready = 1'b1; frame_len = len;
    check("done_seen", 64'(done_seen), 64'd1);
    check("busy_held", 64'(busy_bad), 64'd0);
    if (chk_lat) check("done_latency", 64'(done_cyc - start_cyc), 64'(eff + RD_LAT + 2));
    check("sample_count", 64'(got_d.size()), 64'(eff));
    check("addr_count", 64'(issued.size()), 64'(eff));
    bad = 0; lbad = 0; abad = 0; best = 0; bidx = 0;
    for (int k = 0; k < eff; k++) begin
      if (k < got_d.size() && got_d[k] !== ram[k]) bad++;
      if (k < got_l.size() && got_l[k] !== (k == eff - 1)) lbad++;
      if (k < issued.size() && issued[k] !== ADDR_W'(k)) abad++;
      mag = longint'($signed(ram[k]));
      if (mag < 0) mag = -mag;
      if (mag > best) begin
        best = mag; bidx = k;
      end
    end
    check("data_seq", 64'(bad), 64'd0);
    check("last_flag", 64'(lbad), 64'd0);
    check("addr_seq", 64'(abad), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    check("peak_mag", 64'(peak_mag), 64'(best[31:0]));
    check("peak_idx", 64'(peak_idx), 64'(bidx));
  endtask

  initial begin
    int n;
    logic [ADDR_W:0] rl;
    rst = 1'b1; start = 1'b0; frame_len = '0; m_ready = 1'b1;
    mon_en = 1'b0; stall_pend = 1'b0; h1 = 1'b0; h2 = 1'b0;
    for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk_zero("reset");

    // Ramp frame, full-rate stream.
    for (int k = 0; k < 8; k++) ram[k] = 32'(k * 3 - 10);
    run_frame(11'd8, 0, 1'b1, 1'b0);
    check("ramp_first", 64'(got_d[0]), 64'(32'hFFFF_FFF6));
    check("ramp_last_val", 64'(got_d[7]), 64'd11);
    check("ramp_peak_mag", 64'(peak_mag), 64'd11);
    check("ramp_peak_idx", 64'(peak_idx), 64'd7);

    // Same frame with back-pressure.
    run_frame(11'd8, 1, 1'b0, 1'b0);

    // Tie on the most negative value keeps the first index.
    ram[0] = 32'd5; ram[1] = 32'h8000_0000; ram[2] = 32'd7; ram[3] = 32'h8000_0000;
    run_frame(11'd4, 0, 1'b1, 1'b0);
    check("tie_peak_mag", 64'(peak_mag), 64'h8000_0000);
    check("tie_peak_idx", 64'(peak_idx), 64'd1);

    // Zero-length frame: done next cycle, never busy, no reads.
    issued.delete();
    frame_len = 11'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_busy2", 64'(busy), 64'd0);
    tick();
    check("zero_no_reads", 64'(issued.size()), 64'd0);
    check("zero_peak_mag", 64'(peak_mag), 64'h8000_0000);
    check("zero_peak_idx", 64'(peak_idx), 64'd1);

    // Random frames with random back-pressure.
    repeat (4) begin
      rl = 11'($urandom_range(1, 40));
      for (int k = 0; k < int'(rl); k++) ram[k] = $urandom;
      run_frame(rl, 2, 1'b0, 1'b0);
    end

    // Reset in the middle of a frame.
    for (int k = 0; k < 8; k++) ram[k] = $urandom;
    got_d.delete();
    frame_len = 11'd8; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (got_d.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    check("rst_mid_three_sent", 64'(got_d.size()), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_mid");
    done_seen = 1'b0;
    repeat (6) tick();
    check("rst_mid_no_done", 64'(done_seen), 64'd0);
    check("rst_mid_idle_valid", 64'(m_valid), 64'd0);
    ram[0] = $urandom; ram[1] = $urandom;
    run_frame(11'd2, 0, 1'b1, 1'b0);

    // Full address space with an ignored mid-frame start.
    for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = $urandom;
    run_frame(11'd1024, 0, 1'b1, 1'b1);

    // Oversized length is clamped to the address space.
    run_frame(11'd1500, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beamformer_sum_readout.md
Name: beamformer_sum_readout

Overview:
- Read-side sequencer for the beamformer summed-output signal RAM: drives its address and read enable, absorbs the RAM read latency, and presents each 32-bit beam sample on a ready/valid stream toward the host/UART packer.
- Tracks the peak absolute beam value and its index over each frame.
- Sits downstream of the beamformer top level, on its sumout_address/sumouten/output_value port group.

Parameters:
- ADDR_W, 10, sum RAM address width.
- RD_LATENCY, 2, clocks from rden asserted to valid q (registered-output RAM).
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins frame readout; ignored while busy.
- frame_len  in  ADDR_W+1  number of samples to read; sampled on accepted start.
- sumout_address  out  ADDR_W  sum RAM read address.
- sumouten  out  1  sum RAM read enable.
- output_value  in  32  sum RAM q (signed two's complement).
- m_data  out  32  stream sample.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final sample of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last sample transfers.
- peak_mag  out  32  unsigned max |sample| of the last completed frame.
- peak_idx  out  ADDR_W  index of peak_mag.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, FIFO emptied, in-flight reads discarded. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start with frame_len=0, pulse done next cycle and never assert busy. On start with frame_len>0, latch length, clear the running peak, assert busy, go to ISSUE.
  - ISSUE: assert sumouten with sumout_address=rd_cnt when occupancy+inflight < FIFO_DEPTH, then rd_cnt++. When rd_cnt reaches len-1 and that read issues, go to DRAIN. sumouten=0 otherwise. sumout_address holds its last value when not reading.
  - DRAIN: wait until the FIFO is empty and the last transfer (m_valid&&m_ready&&m_last) has occurred, then go to FINISH.
  - FINISH: pulse done for 1 cycle, drop busy, commit peak_mag/peak_idx, return to IDLE.
- Read pipeline: a RD_LATENCY-deep shift register of tag bits marks returning data. output_value is captured into the FIFO exactly RD_LATENCY cycles after sumouten. inflight counts issued reads not yet captured.
- Credit rule guarantees FIFO never overflows; a capture into a full FIFO is a design error (assertion).
- Stream:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - Transfer when m_valid&&m_ready; head pops the same edge.
  - m_data and m_last are stable while m_valid&&!m_ready.
  - Simultaneous push and pop is allowed; occupancy is unchanged.
- m_last: asserted on the head entry whose index == len-1. The FIFO stores a last flag per entry.
- Throughput: with m_ready held high, one sample per clock after an initial RD_LATENCY+1 cycles. Frame of N completes N+RD_LATENCY+2 cycles after start (done asserted).
- Peak tracking: updated at FIFO push.
  - Absolute value: |x| computed as unsigned 32 bits; |-2^31| = 0x80000000.
  - Update only if |x| > running max (strict), so ties keep the earliest index.
  - Outputs change only in FINISH; values hold until the next completed frame.
- Address wrap: frame_len up to 2^ADDR_W is legal. Larger values are clamped to 2^ADDR_W. Addresses never wrap within a frame.
- start in the same cycle as done/FINISH is ignored (busy still 1).

Test Plan:
- frame_len=8, RAM preloaded k*3-10 for k=0..7, m_ready=1 -> m_data -10,-7,-4,-1,2,5,8,11 on consecutive cycles; m_last on 11; done 1 cycle after; peak_mag=11, peak_idx=7.
- Same frame, m_ready toggles 1,0,0,1 pattern -> no sample lost/duplicated; sumouten never asserted when occupancy+inflight=4; data stable while stalled.
- RAM values {5,-0x80000000,7,-0x80000000} -> peak_mag=0x80000000, peak_idx=1 (tie keeps first).
- frame_len=0 start -> done pulse next cycle, busy stays 0, no sumouten, peak outputs unchanged.
- rst asserted mid-frame after 3 samples transferred -> next cycle all outputs 0, no done; subsequent start frame_len=2 reads addresses 0,1 cleanly.
- frame_len=1024 (ADDR_W=10) with m_ready=1 -> addresses 0..1023 exactly once; m_last on index 1023; done at cycle 1024+RD_LATENCY+2 after start; start pulsed mid-frame ignored.
